// File: rtl/svpwm_modgen.sv
// Three-phase DDS modulating-wave generator: shared sine ROM, amplitude scaling, min/max injection.
// Optional macro SVPWM_MODGEN_SPWM_MODE_EN adds mode_spwm, which bypasses the common-mode injection.
module svpwm_modgen #(
  parameter int DATA_W   = 16,
  parameter int PHASE_W  = 32,
  parameter int LUT_AW   = 10,
  parameter int TICK_DIV = 50
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clk_enable,
  output logic                     ce_out,
  input  logic [PHASE_W-1:0]       freq_word,
  input  logic                     freq_load,
  input  logic [15:0]              amp,
`ifdef SVPWM_MODGEN_SPWM_MODE_EN
  input  logic                     mode_spwm,
`endif
  output logic signed [DATA_W-1:0] out_a,
  output logic signed [DATA_W-1:0] out_b,
  output logic signed [DATA_W-1:0] out_c,
  output logic                     out_valid
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int LUT_N = 2 ** LUT_AW;
  localparam int QTR   = LUT_N / 4;
  localparam logic [PHASE_W+1:0] ONE_TURN = (PHASE_W+2)'(1) << PHASE_W;
  localparam logic [PHASE_W-1:0] OFS      = PHASE_W'((ONE_TURN + 1) / 3);
  localparam logic signed [127:0] PI_Q60  = 128'sh3243F6A8885A308D;

  // Elaboration-time sine in Q60 fixed point (quadrant folding + Taylor series), rounded to DATA_W.
  function automatic logic signed [DATA_W-1:0] sin_entry(input int k);
    logic signed [127:0] x, x2, term, acc, fs;
    int r;
    r = k % (LUT_N / 2);
    if (r > QTR) r = LUT_N / 2 - r;
    x    = (PI_Q60 * 128'(2 * r)) / 128'(LUT_N);
    x2   = (x * x) >>> 60;
    term = x;
    acc  = x;
    for (int n = 1; n < 16; n++) begin
      term = -((term * x2) >>> 60) / 128'(2 * n * (2 * n + 1));
      acc  = acc + term;
    end
    fs  = 128'((1 << (DATA_W - 1)) - 1);
    acc = (acc * fs + (128'sd1 <<< 59)) >>> 60;
    return (k >= LUT_N / 2) ? DATA_W'(-acc) : DATA_W'(acc);
  endfunction

  function automatic logic [15:0] clamp_amp(input logic [15:0] a);
    return (a > 16'd32768) ? 16'd32768 : a;
  endfunction

  function automatic logic signed [DATA_W-1:0] scale_amp(input logic signed [DATA_W-1:0] s,
                                                         input logic [15:0] a);
    logic signed [DATA_W+16:0] prod;
    prod = (DATA_W+17)'(s) * (DATA_W+17)'($signed({1'b0, a}));
    return DATA_W'(prod >>> 15);
  endfunction

  function automatic logic signed [DATA_W-1:0] max3(input logic signed [DATA_W-1:0] p, q, r);
    logic signed [DATA_W-1:0] m;
    m = (p > q) ? p : q;
    return (m > r) ? m : r;
  endfunction

  function automatic logic signed [DATA_W-1:0] min3(input logic signed [DATA_W-1:0] p, q, r);
    logic signed [DATA_W-1:0] m;
    m = (p < q) ? p : q;
    return (m < r) ? m : r;
  endfunction

  function automatic logic signed [DATA_W:0] common_mode(input logic signed [DATA_W-1:0] hi, lo);
    logic signed [DATA_W:0] sum;
    sum = (DATA_W+1)'(hi) + (DATA_W+1)'(lo);
    return sum >>> 1;
  endfunction

  logic signed [DATA_W-1:0] rom [LUT_N];
  for (genvar k = 0; k < LUT_N; k++) begin : g_rom
    localparam logic signed [DATA_W-1:0] ENTRY = sin_entry(k);
    assign rom[k] = ENTRY;
  end

  logic [CNT_W-1:0]   cnt;
  logic               tick;
  logic [PHASE_W-1:0] phase_acc, freq_reg;
  logic [15:0]        amp_reg;
  logic [LUT_AW-1:0]  idx_a, idx_b, idx_c;
  logic               vld_p0, vld_p1, vld_p2, vld_p3, vld_p4;
  logic signed [DATA_W-1:0] lut_a_p1, lut_b_p1, lut_c_p1;
  logic signed [DATA_W-1:0] v_a_p2, v_b_p2, v_c_p2;
  logic signed [DATA_W-1:0] v_a_p3, v_b_p3, v_c_p3, mx_p3, mn_p3;
  logic signed [DATA_W:0]   cm_p3;
`ifdef SVPWM_MODGEN_SPWM_MODE_EN
  logic mode_reg;
`endif

  assign tick   = (cnt == CNT_W'(TICK_DIV - 1));
  assign idx_a  = phase_acc[PHASE_W-1 -: LUT_AW];
  assign idx_b  = LUT_AW'((phase_acc - OFS) >> (PHASE_W - LUT_AW));
  assign idx_c  = LUT_AW'((phase_acc + OFS) >> (PHASE_W - LUT_AW));
  assign ce_out = clk_enable;
  // The strobe register holds while disabled, so it must be masked here to stay one-shot.
  assign out_valid = vld_p4 & clk_enable;

  always_comb begin
    cm_p3 = common_mode(mx_p3, mn_p3);
`ifdef SVPWM_MODGEN_SPWM_MODE_EN
    if (mode_reg) cm_p3 = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      phase_acc <= '0;
      freq_reg  <= '0;
      amp_reg   <= '0;
`ifdef SVPWM_MODGEN_SPWM_MODE_EN
      mode_reg  <= 1'b0;
`endif
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      vld_p3    <= 1'b0;
      vld_p4    <= 1'b0;
      lut_a_p1  <= '0;
      lut_b_p1  <= '0;
      lut_c_p1  <= '0;
      v_a_p2    <= '0;
      v_b_p2    <= '0;
      v_c_p2    <= '0;
      v_a_p3    <= '0;
      v_b_p3    <= '0;
      v_c_p3    <= '0;
      mx_p3     <= '0;
      mn_p3     <= '0;
      out_a     <= '0;
      out_b     <= '0;
      out_c     <= '0;
    end else if (clk_enable) begin
      // P0: sample tick, phase and amplitude update
      cnt <= tick ? '0 : cnt + CNT_W'(1);
      if (freq_load) freq_reg <= freq_word;
      if (tick) begin
        phase_acc <= phase_acc + freq_reg;
        amp_reg   <= clamp_amp(amp);
`ifdef SVPWM_MODGEN_SPWM_MODE_EN
        mode_reg  <= mode_spwm;
`endif
      end
      vld_p0 <= tick;
      // P1: registered ROM reads
      lut_a_p1 <= rom[idx_a];
      lut_b_p1 <= rom[idx_b];
      lut_c_p1 <= rom[idx_c];
      vld_p1   <= vld_p0;
      // P2: amplitude scaling
      v_a_p2 <= scale_amp(lut_a_p1, amp_reg);
      v_b_p2 <= scale_amp(lut_b_p1, amp_reg);
      v_c_p2 <= scale_amp(lut_c_p1, amp_reg);
      vld_p2 <= vld_p1;
      // P3: extremes of the three phases
      mx_p3  <= max3(v_a_p2, v_b_p2, v_c_p2);
      mn_p3  <= min3(v_a_p2, v_b_p2, v_c_p2);
      v_a_p3 <= v_a_p2;
      v_b_p3 <= v_b_p2;
      v_c_p3 <= v_c_p2;
      vld_p3 <= vld_p2;
      // P4: common-mode removal; outputs hold between strobes
      if (vld_p3) begin
        out_a <= DATA_W'((DATA_W+1)'(v_a_p3) - cm_p3);
        out_b <= DATA_W'((DATA_W+1)'(v_b_p3) - cm_p3);
        out_c <= DATA_W'((DATA_W+1)'(v_c_p3) - cm_p3);
      end
      vld_p4 <= vld_p3;
    end
  end

  tick_div_legal: assert property (@(posedge clk) TICK_DIV >= 5);

endmodule
